gain_restore_80: RTL and testbench
==================================

# gain_restore_80

Sequential inverse of the 80 % brightness-scaling table in the LED colour path. It takes an 8-bit channel value y and returns the smallest 8-bit x with floor(x·PCT_NUM/PCT_DEN) ≥ y, saturating at 255. The result is computed with a multi-cycle restoring divider behind valid/ready handshakes on both sides. It sits between the spectrum/colour stage and any logic that must recover pre-attenuation levels, for example when re-normalising or comparing against unscaled thresholds.

## Interface
Parameters:
- PCT_NUM, default 80: gain numerator, used as the divisor. Range 1..PCT_DEN.
- PCT_DEN, default 100: gain denominator, used as the multiplier. Range 1..127.
- W, default 8+$clog2(PCT_DEN+1) = 15: dividend width and divider iteration count. Derived; do not override.

Ports:
- clk, input, 1: the single clock. Rising edge.
- rst_n, input, 1: reset. Asynchronous, active-low.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept. High only in IDLE.
- in_data, input, 8: scaled value y.
- out_valid, output, 1: result is valid. High only in DONE.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, 8: restored value x.
- out_sat, output, 1: the true result exceeded 255 and out_data was clamped.
- busy, output, 1: state is not IDLE.

## Operation
- The required function is out_data = min(255, ceil(y·PCT_DEN/PCT_NUM)). out_sat = 1 when ceil(y·PCT_DEN/PCT_NUM) > 255.
- With the defaults, y ≤ 204 round-trips exactly through the 80 % table, and y ≥ 205 gives 255 with out_sat = 1.
- FSM states: IDLE, DIV, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: dividend ← y·PCT_DEN (W bits, exact, no truncation), remainder ← 0, quotient ← 0, count ← 0, go to DIV.
- DIV:
  - Each cycle performs one restoring step, MSB first.
  - rem' = {rem, dividend[W-1-count]}.
  - If rem' ≥ PCT_NUM: rem ← rem' − PCT_NUM and the quotient bit is 1. Otherwise rem ← rem' and the quotient bit is 0.
  - The quotient shifts left by one and takes the new bit in its LSB.
  - The remainder register is $clog2(PCT_NUM)+1 bits wide. The quotient register is W bits wide.
  - After W steps (count == W−1 on the step edge), go to FIX.
- FIX (one cycle):
  - q_c = quotient + (rem != 0).
  - If q_c > 255: out_data ← 255 and out_sat ← 1. Otherwise out_data ← q_c[7:0] and out_sat ← 0.
  - Go to DONE.
- DONE:
  - out_valid = 1. out_data and out_sat are held stable.
  - On out_ready, go to IDLE.
  - in_ready is 0 in DONE, so a new input is never accepted in the same cycle a result is consumed.
- in_data is sampled only at the accept edge. Changes to it while busy are ignored.
- in_valid arriving while busy is not accepted, and no state changes because of it.
- Upstream must hold in_valid until in_ready.

## Timing
- Reset (rst_n = 0, asynchronous, at any time including mid-division):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_data = 0, out_sat = 0.
  - All datapath registers = 0.
- Release of rst_n is synchronous to clk. The first accept can occur on the first edge with rst_n high.
- Latency, counting the accept edge as edge 0:
  - DIV runs on edges 1..W.
  - FIX registers the output on edge W+1 = 16. out_valid is high from edge 16 onward.
- out_valid stays high with stable data until the edge on which out_ready is sampled high. That edge returns the block to IDLE, and in_ready = 1 in the following cycle.
- Minimum initiation interval with out_ready tied high: W+3 = 18 cycles (accept, W DIV cycles, FIX, DONE, then IDLE).
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- busy = (state != IDLE).

## Test plan
- Exhaustive sweep: drive y = 0..255 with out_ready = 1. The response must be out_data = min(255, ceil(y·100/80)), for example y = 0→0, 1→2, 4→5, 102→128, 204→255. out_sat must be 0 for y ≤ 204 and 1 for y ≥ 205 (205→255, 255→255). For y ≤ 204, floor(out_data·0.8) must equal y.
- Latency and handshake: accept y = 64 at edge 0. Require out_valid to rise exactly at edge 16 with out_data = 80, and in_ready = 0 on edges 1..16.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid rises with y = 3. out_data must stay 4 and out_valid must stay 1 throughout. Changing in_data and asserting in_valid meanwhile must cause no accept. Raising out_ready returns the block to IDLE on the next edge.
- Reset mid-operation: accept y = 200, then pull rst_n low asynchronously at edge 7 + half a cycle. All outputs must immediately take their reset values. After release, y = 10 must produce 13 at edge 16 after its accept.
- Back-to-back: present y = 50 then y = 51 continuously with out_ready = 1. Results must be 63 then 64, and the accepts must be 18 cycles apart.

Source files
------------

// File: rtl/gain_restore_80.sv
// Inverse of the 80 % brightness table: x = min(255, ceil(y*PCT_DEN/PCT_NUM)),
// computed by a W-step restoring divider between valid/ready handshakes.
module gain_restore_80 #(
    parameter int unsigned PCT_NUM = 80,
    parameter int unsigned PCT_DEN = 100,
    parameter int unsigned W       = 8 + $clog2(PCT_DEN + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sat,
    output logic       busy
);

    localparam int unsigned RW = $clog2(PCT_NUM) + 1;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   div_q, div_d;
    logic [RW-1:0]  rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     data_q, data_d;
    logic           sat_q, sat_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;

    logic [RW:0]    rem_shift;
    logic [W:0]     q_c;

    // Next-state and datapath; the dividend shifts left so its MSB feeds each step
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        sat_d     = sat_q;
        rem_shift = {rem_q, div_q[W-1]};
        q_c       = (W+1)'(quo_q) + (W+1)'(rem_q != '0);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d   = W'(in_data) * W'(PCT_DEN);
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                div_d = {div_q[W-2:0], 1'b0};
                if (rem_shift >= (RW+1)'(PCT_NUM)) begin
                    rem_d = RW'(rem_shift - (RW+1)'(PCT_NUM));
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = RW'(rem_shift);
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                cnt_d = CW'(cnt_q + CW'(1));
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (q_c > (W+1)'(255)) begin
                    data_d = 8'hFF;
                    sat_d  = 1'b1;
                end else begin
                    data_d = q_c[7:0];
                    sat_d  = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gain_restore_80.sv
// Bench for gain_restore_80: directed vector table, exhaustive sweep, random
// backpressure, and hand-built latency / reset / back-to-back sequences.
module tb_gain_restore_80;

    localparam int NUM = 80;
    localparam int DEN = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sat;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gain_restore_80 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] y;
        logic [7:0] x;
        logic       sat;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: ceiling division then clamp
    function automatic int ref_full(input int y);
        return (y * DEN + NUM - 1) / NUM;
    endfunction

    function automatic int ref_x(input int y);
        return (ref_full(y) > 255) ? 255 : ref_full(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer y, wait for the result, hold out_ready low for `hold` cycles, then consume
    task automatic txn(input logic [7:0] y, input int hold,
                       output logic [7:0] d, output logic s, output int lat);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = y;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        d = out_data;
        s = out_sat;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'(d));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("back_to_idle", int'(in_ready), 1);
    endtask

    initial begin
        logic [7:0] d;
        logic       s;
        int         lat;
        int         y;
        int         cyc;
        int         acc_t [2];
        int         n_acc;
        int         res [$];

        tbl[0]  = '{8'd0,   8'd0,   1'b0};
        tbl[1]  = '{8'd1,   8'd2,   1'b0};
        tbl[2]  = '{8'd4,   8'd5,   1'b0};
        tbl[3]  = '{8'd102, 8'd128, 1'b0};
        tbl[4]  = '{8'd204, 8'd255, 1'b0};
        tbl[5]  = '{8'd205, 8'd255, 1'b1};
        tbl[6]  = '{8'd255, 8'd255, 1'b1};
        tbl[7]  = '{8'd64,  8'd80,  1'b0};
        tbl[8]  = '{8'd3,   8'd4,   1'b0};
        tbl[9]  = '{8'd10,  8'd13,  1'b0};
        tbl[10] = '{8'd50,  8'd63,  1'b0};
        tbl[11] = '{8'd51,  8'd64,  1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].y, 0, d, s, lat);
            chk($sformatf("tbl_data y=%0d", tbl[i].y), int'(d), int'(tbl[i].x));
            chk($sformatf("tbl_sat y=%0d", tbl[i].y), int'(s), int'(tbl[i].sat));
            chk($sformatf("tbl_lat y=%0d", tbl[i].y), lat, 16);
        end

        for (int v = 0; v < 256; v++) begin
            txn(8'(v), 0, d, s, lat);
            chk($sformatf("sweep_data y=%0d", v), int'(d), ref_x(v));
            chk($sformatf("sweep_sat y=%0d", v), int'(s), (ref_full(v) > 255) ? 1 : 0);
            if (v <= 204) chk($sformatf("roundtrip y=%0d", v), (int'(d) * NUM) / DEN, v);
        end

        for (int k = 0; k < 100; k++) begin
            y = int'($urandom_range(0, 255));
            txn(8'(y), int'($urandom_range(0, 3)), d, s, lat);
            chk($sformatf("rand_data y=%0d", y), int'(d), ref_x(y));
            chk($sformatf("rand_sat y=%0d", y), int'(s), (ref_full(y) > 255) ? 1 : 0);
        end

        // Exact latency: accept y=64 at edge 0, result must appear at edge 16
        in_valid = 1'b1;
        in_data  = 8'd64;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("lat_in_ready e%0d", k), int'(in_ready), 0);
            chk($sformatf("lat_out_valid e%0d", k), int'(out_valid), (k == 16) ? 1 : 0);
        end
        chk("lat_data", int'(out_data), 80);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Backpressure with y=3 while a competing input is offered
        in_valid = 1'b1;
        in_data  = 8'd3;
        tick();
        in_data = 8'd200;
        for (int k = 1; k <= 16; k++) tick();
        chk("bp_rise", int'(out_valid), 1);
        for (int k = 0; k < 10; k++) begin
            in_data = 8'($urandom);
            tick();
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_data", int'(out_data), 4);
            chk("bp_no_accept", int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);
        chk("bp_release_busy", int'(busy), 0);

        // Asynchronous reset in the middle of a division
        in_valid = 1'b1;
        in_data  = 8'd200;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        chk("mid_busy_before", int'(busy), 1);
        #4 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        chk("mid_rst_out_sat", int'(out_sat), 0);
        #7 rst_n = 1'b1;
        tick();
        txn(8'd10, 0, d, s, lat);
        chk("post_rst_data", int'(d), 13);
        chk("post_rst_lat", lat, 16);

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd50;
        cyc   = 0;
        n_acc = 0;
        while ((res.size() < 2) && (cyc < 80)) begin
            logic acc_now;
            acc_now = in_valid && in_ready;
            if (acc_now) acc_t[n_acc] = cyc + 1;
            tick();
            cyc++;
            if (acc_now) begin
                n_acc++;
                if (n_acc == 1) in_data = 8'd51;
                else in_valid = 1'b0;
            end
            if (out_valid) res.push_back(int'(out_data));
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_results", res.size(), 2);
        chk("b2b_accepts", n_acc, 2);
        if (res.size() == 2) begin
            chk("b2b_first", res[0], 63);
            chk("b2b_second", res[1], 64);
        end
        if (n_acc == 2) chk("b2b_interval", acc_t[1] - acc_t[0], 18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
